// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and defaults for the int8 MAC sequencer
// Contents:
//   MAC_DATA_W  default operand width
//   state_t     sequencer FSM states
package mac_pkg;

  localparam int MAC_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mac_int8_sequencer.sv
// rtl/mac_int8_sequencer.sv - weight/activation sequencer feeding a preloadable int8 MAC
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   start, cfg_len, cfg_tiles       job request and its geometry (sampled in IDLE only)
//   busy, done                      job active, one-cycle completion pulse
//   w_valid, w_ready, w_data        weight stream, one weight per tile
//   a_valid, a_ready, a_data        activation stream, cfg_len activations per tile
//   mac_weight_in, mac_preload_weight, mac_load_weight,
//   mac_enable, mac_input_val       MAC control (preload buffer, active weight, operand)
//   mac_out_valid                   MAC result strobe, retires outstanding operations
module mac_int8_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W    = MAC_DATA_W,
  parameter int MAX_LEN   = 256,
  parameter int MAX_TILES = 256,
  parameter int CNT_W     = $clog2(MAX_LEN + 1),
  parameter int TILE_W    = $clog2(MAX_TILES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [TILE_W-1:0] cfg_tiles,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] mac_weight_in,
  output logic              mac_preload_weight,
  output logic              mac_load_weight,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_input_val,
  input  logic              mac_out_valid
);

  localparam int OUT_W = $clog2(MAX_LEN * MAX_TILES + 1);

  state_t              state;
  logic [CNT_W-1:0]    len_q;
  logic [TILE_W-1:0]   tiles_q;
  logic [CNT_W-1:0]    act_cnt;      // activations consumed in the current tile
  logic [TILE_W-1:0]   loaded_cnt;   // weights made active in the MAC
  logic [TILE_W-1:0]   fetched_cnt;  // weights transferred from the stream
  logic                preloaded;    // next weight sits in the MAC preload buffer
  logic [OUT_W-1:0]    outst;
  logic [OUT_W-1:0]    outst_next;
  logic [DATA_W-1:0]   weight_q;
  logic [DATA_W-1:0]   input_q;

  logic w_fire;
  logic a_fire;
  logic last_act;
  logic tiles_left;
  logic swap;
  logic inc;
  logic dec;

  // Ready signals depend on registered state only, never on the valids.
  assign a_ready    = (state == ST_STREAM);
  assign w_ready    = (state == ST_FETCH) ||
                      ((state == ST_STREAM) && (fetched_cnt != tiles_q) && !preloaded);

  assign w_fire     = w_valid && w_ready;
  assign a_fire     = a_valid && a_ready;
  assign last_act   = a_fire && (act_cnt == len_q - CNT_W'(1));
  assign tiles_left = (loaded_cnt != tiles_q);
  // Zero-bubble tile switch: activate the preloaded weight alongside the last operand.
  assign swap       = last_act && tiles_left && preloaded;

  assign busy               = (state != ST_IDLE);
  assign done               = (state == ST_DONE);
  assign mac_preload_weight = w_fire;
  assign mac_weight_in      = w_fire ? w_data : weight_q;
  assign mac_load_weight    = (state == ST_LOAD) || swap;
  assign mac_enable         = a_fire;
  assign mac_input_val      = a_fire ? a_data : input_q;

  // Stray result strobes outside a job, or with nothing in flight, never underflow.
  assign inc = a_fire;
  assign dec = mac_out_valid && (state != ST_IDLE) && (outst != '0);

  always_comb begin
    outst_next = outst + OUT_W'(inc) - OUT_W'(dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      tiles_q     <= '0;
      act_cnt     <= '0;
      loaded_cnt  <= '0;
      fetched_cnt <= '0;
      preloaded   <= 1'b0;
      outst       <= '0;
      weight_q    <= '0;
      input_q     <= '0;
    end else begin
      outst <= outst_next;
      if (w_fire) begin
        weight_q    <= w_data;
        fetched_cnt <= fetched_cnt + TILE_W'(1);
      end
      if (a_fire) begin
        input_q <= a_data;
        act_cnt <= last_act ? '0 : act_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q       <= cfg_len;
            tiles_q     <= cfg_tiles;
            act_cnt     <= '0;
            loaded_cnt  <= '0;
            fetched_cnt <= '0;
            preloaded   <= 1'b0;
            state       <= ((cfg_len == '0) || (cfg_tiles == '0)) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_fire) state <= ST_LOAD;
        end
        ST_LOAD: begin
          loaded_cnt <= loaded_cnt + TILE_W'(1);
          state      <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_fire) preloaded <= 1'b1;
          if (last_act) begin
            if (!tiles_left) begin
              state <= ST_DRAIN;
            end else if (preloaded) begin
              loaded_cnt <= loaded_cnt + TILE_W'(1);
              preloaded  <= 1'b0;
            end else if (w_fire) begin
              // Weight arrived with the last operand: it is preloaded now, load it next cycle.
              preloaded <= 1'b0;
              state     <= ST_LOAD;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_DRAIN: begin
          if (outst_next == '0) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_int8_sequencer.sv
// tb/tb_mac_int8_sequencer.sv - directed scoreboard bench for mac_int8_sequencer
module tb_mac_int8_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] cfg_len;
  logic [8:0] cfg_tiles;
  logic       busy, done;
  logic       w_valid, w_ready;
  logic [7:0] w_data;
  logic       a_valid, a_ready;
  logic [7:0] a_data;
  logic [7:0] mac_weight_in;
  logic       mac_preload_weight, mac_load_weight, mac_enable;
  logic [7:0] mac_input_val;
  logic       mac_out_valid;

  always #5 clk = ~clk;

  mac_int8_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .mac_weight_in(mac_weight_in), .mac_preload_weight(mac_preload_weight),
    .mac_load_weight(mac_load_weight), .mac_enable(mac_enable),
    .mac_input_val(mac_input_val), .mac_out_valid(mac_out_valid)
  );

  // Behavioural MAC: preload buffer, active weight, two-stage result pipeline.
  logic signed [7:0]  pre_w, act_w;
  logic               p1_v, p2_v;
  logic signed [15:0] p1_d, p2_d;
  logic               extra_ov;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_w <= '0; act_w <= '0;
      p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
    end else begin
      if (mac_preload_weight) pre_w <= $signed(mac_weight_in);
      if (mac_load_weight)    act_w <= pre_w;
      p1_v <= mac_enable;
      p1_d <= act_w * $signed(mac_input_val);
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end
  assign mac_out_valid = p2_v | extra_ov;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] sb[$];
  logic signed [7:0]  wv[0:7];
  logic signed [7:0]  av[0:15];

  int ncyc = 0;
  int n_pre, n_load, n_load_en, n_en, n_done, n_res, done_cyc, last_ov;
  int n_en_tot = 0;
  int n_res_tot = 0;
  int en_cyc[$];
  int load_cyc[$];
  int pre_cyc[$];

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_step();
    logic signed [15:0] exp_r;
    ncyc++;
    if (mac_preload_weight) begin n_pre++; pre_cyc.push_back(ncyc); end
    if (mac_load_weight) begin
      n_load++; load_cyc.push_back(ncyc);
      if (mac_enable) n_load_en++;
    end
    if (mac_enable) begin n_en++; n_en_tot++; en_cyc.push_back(ncyc); end
    if (done) begin n_done++; done_cyc = ncyc; end
    if (p2_v) begin
      n_res++; n_res_tot++; last_ov = ncyc;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed result %0d expected none", p2_d);
      end
      if (sb.size() > 0) begin
        exp_r = sb.pop_front();
        checks++;
        assert (p2_d === exp_r) else begin
          errors++;
          $error("FAIL mac_result observed %0d expected %0d", p2_d, exp_r);
        end
      end
    end
    checks++;
    assert (!(mac_preload_weight && mac_load_weight)) else begin
      errors++;
      $error("FAIL preload_load_same_cycle observed 1 expected 0 at cycle %0d", ncyc);
    end
    checks++;
    assert (n_res_tot <= n_en_tot) else begin
      errors++;
      $error("FAIL outstanding_negative observed results %0d expected <= enables %0d", n_res_tot, n_en_tot);
    end
  endtask

  task automatic clear_stats();
    n_pre = 0; n_load = 0; n_load_en = 0; n_en = 0; n_done = 0; n_res = 0;
    done_cyc = -1; last_ov = -1;
    en_cyc.delete(); load_cyc.delete(); pre_cyc.delete();
  endtask

  task automatic drive_weights(input int n, input int widx, input int wdel);
    int k;
    for (int i = 0; i < n; i++) begin
      if (i == widx) begin
        repeat (wdel) @(posedge clk);
        #1;
      end
      w_valid = 1'b1; w_data = wv[i];
      @(negedge clk); k = 1;
      while (w_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      chk("w_ready_wait", w_ready, 1);
      if (w_ready !== 1'b1) begin w_valid = 1'b0; return; end
      @(posedge clk); #1;
      w_valid = 1'b0;
    end
  endtask

  task automatic drive_acts(input int n, input int len, input bit toggle);
    int k;
    logic signed [15:0] e;
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1; a_data = av[i];
      @(negedge clk); k = 1;
      while (a_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      chk("a_ready_wait", a_ready, 1);
      if (a_ready !== 1'b1) begin a_valid = 1'b0; return; end
      @(posedge clk);
      e = wv[i / len] * av[i];
      sb.push_back(e);
      #1;
      a_valid = 1'b0;
      if (toggle) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (n_done == 0 && k < 300) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("done_count", n_done, 1);
  endtask

  task automatic run_job(input int len, input int tiles, input bit toggle,
                         input int widx, input int wdel, input bit poke);
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 9'(len); cfg_tiles = 9'(tiles);
    @(posedge clk); #1;
    start = 1'b0;
    fork
      drive_weights(tiles, widx, wdel);
      drive_acts(len * tiles, len, toggle);
      begin
        if (poke) begin
          repeat (3) @(posedge clk); #1;
          start = 1'b1; cfg_len = 9'd0; cfg_tiles = 9'd0;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    wait_done();
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_tiles = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; extra_ov = 1'b0;
    clear_stats();
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_mac_strobes", {mac_preload_weight, mac_load_weight, mac_enable}, 0);
    chk("rst_mac_weight_in", mac_weight_in, 0);
    chk("rst_mac_input_val", mac_input_val, 0);
    reset = 1'b0;

    // Single tile, back-to-back activations
    wv[0] = 8'sd5; av[0] = 8'sd1; av[1] = 8'sd2; av[2] = 8'sd3;
    run_job(3, 1, 1'b0, -1, 0, 1'b0);
    chk("a_preloads", n_pre, 1);
    chk("a_loads", n_load, 1);
    chk("a_enables", n_en, 3);
    chk("a_results", n_res, 3);
    chk("a_enable_span", qget(en_cyc, 2) - qget(en_cyc, 0), 2);
    chk("a_done_after_last_result", done_cyc, last_ov + 1);

    // Three tiles, weights available early: zero-bubble switches
    wv[0] = 8'sd2; wv[1] = -8'sd3; wv[2] = 8'sd4;
    av[0] = 8'sd3; av[1] = -8'sd1; av[2] = 8'sd7; av[3] = 8'sd2; av[4] = -8'sd5; av[5] = 8'sd6;
    run_job(2, 3, 1'b0, -1, 0, 1'b0);
    chk("b_enables", n_en, 6);
    chk("b_enable_span", qget(en_cyc, 5) - qget(en_cyc, 0), 5);
    chk("b_loads", n_load, 3);
    chk("b_loads_with_enable", n_load_en, 2);
    chk("b_results", n_res, 6);
    chk("b_done_after_last_result", done_cyc, last_ov + 1);

    // Second weight delayed: FETCH gap, no enables until the load completes
    wv[0] = 8'sd3; wv[1] = -8'sd2;
    av[0] = 8'sd4; av[1] = 8'sd5; av[2] = 8'sd6; av[3] = 8'sd7;
    run_job(2, 2, 1'b0, 1, 5, 1'b0);
    chk("c_enables", n_en, 4);
    chk("c_loads", n_load, 2);
    chk("c_loads_with_enable", n_load_en, 0);
    chk("c_weight_after_tile0", qget(pre_cyc, 1) > qget(en_cyc, 1), 1);
    chk("c_enable_after_load", qget(en_cyc, 2) > qget(load_cyc, 1), 1);
    chk("c_done_after_last_result", done_cyc, last_ov + 1);

    // a_valid toggling
    wv[0] = 8'sd6; wv[1] = -8'sd7;
    av[0] = 8'sd8; av[1] = 8'sd9; av[2] = -8'sd10; av[3] = 8'sd11;
    run_job(2, 2, 1'b1, -1, 0, 1'b0);
    chk("d_enables", n_en, 4);
    chk("d_enable_gap", qget(en_cyc, 1) - qget(en_cyc, 0), 2);
    chk("d_enable_span", qget(en_cyc, 3) - qget(en_cyc, 0), 6);
    chk("d_done_after_last_result", done_cyc, last_ov + 1);

    // Stray result strobes in IDLE must not underflow the outstanding count
    @(posedge clk); #1; extra_ov = 1'b1;
    repeat (2) @(posedge clk); #1; extra_ov = 1'b0;
    wv[0] = -8'sd8; av[0] = -8'sd128;
    run_job(1, 1, 1'b0, -1, 0, 1'b0);
    chk("e_results", n_res, 1);
    chk("e_done_after_last_result", done_cyc, last_ov + 1);

    // Zero-length and zero-tile jobs
    clear_stats();
    @(posedge clk); #1; start = 1'b1; cfg_len = 9'd0; cfg_tiles = 9'd2;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("f_len0_done", done, 1);
    chk("f_len0_busy", busy, 1);
    @(negedge clk);
    chk("f_len0_done_end", done, 0);
    chk("f_len0_idle", busy, 0);
    @(posedge clk); #1; start = 1'b1; cfg_len = 9'd3; cfg_tiles = 9'd0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("f_tiles0_done", done, 1);
    repeat (2) @(negedge clk);
    chk("f_no_mac_activity", n_pre + n_load + n_en, 0);

    // Start while busy is ignored
    wv[0] = 8'sd1; wv[1] = 8'sd2;
    av[0] = 8'sd1; av[1] = 8'sd2; av[2] = 8'sd3; av[3] = 8'sd4;
    run_job(2, 2, 1'b0, -1, 0, 1'b1);
    chk("g_enables", n_en, 4);
    chk("g_results", n_res, 4);

    // Reset in the middle of STREAM
    clear_stats();
    @(posedge clk); #1; start = 1'b1; cfg_len = 9'd4; cfg_tiles = 9'd1;
    @(posedge clk); #1; start = 1'b0;
    w_valid = 1'b1; w_data = 8'sd9;
    begin
      int k;
      k = 0;
      while (a_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    end
    chk("h_in_stream", a_ready, 1);
    w_valid = 1'b0;
    d0 = n_done;
    reset = 1'b1;
    #1;
    chk("h_rst_busy", busy, 0);
    chk("h_rst_a_ready", a_ready, 0);
    chk("h_rst_w_ready", w_ready, 0);
    chk("h_rst_strobes", {mac_preload_weight, mac_load_weight, mac_enable, done}, 0);
    chk("h_rst_input_val", mac_input_val, 0);
    chk("h_rst_weight_in", mac_weight_in, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("h_no_done", n_done, d0);
    wv[0] = 8'sd7; av[0] = 8'sd3;
    run_job(1, 1, 1'b0, -1, 0, 1'b0);
    chk("h_fresh_results", n_res, 1);
    chk("h_fresh_done_after_result", done_cyc, last_ov + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_int8_sequencer.md
MAC_INT8_SEQUENCER -- requirements
Module: mac_int8_sequencer

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, operand width; MAX_LEN, default 256, max activations per weight; MAX_TILES, default 256, max weights per job; CNT_W, default $clog2(MAX_LEN+1), length counter width; TILE_W, default $clog2(MAX_TILES+1), tile counter width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have job ports: start  input  1  job request pulse; cfg_len  input  CNT_W  activations per weight; cfg_tiles  input  TILE_W  weights in job; busy  output  1  job active; done  output  1  one-cycle completion pulse.
REQ-004 SHALL have weight stream ports: w_valid  input  1; w_ready  output  1; w_data  input  DATA_W  signed weight.
REQ-005 SHALL have activation stream ports: a_valid  input  1; a_ready  output  1; a_data  input  DATA_W  signed activation.
REQ-006 SHALL have MAC-side ports: mac_weight_in  output  DATA_W; mac_preload_weight  output  1; mac_load_weight  output  1; mac_enable  output  1; mac_input_val  output  DATA_W; mac_out_valid  input  1  result strobe from MAC.

Function
REQ-007 SHALL sample cfg_len and cfg_tiles only on a start accepted in IDLE; start while busy is ignored.
REQ-008 SHALL, on start with cfg_len==0 or cfg_tiles==0, pulse done in the next cycle with no MAC-side activity.
REQ-009 SHALL implement states IDLE, FETCH (wait first/next weight), LOAD, STREAM, DRAIN, DONE; busy=1 in all states except IDLE.
REQ-010 SHALL transfer a weight only when w_valid&&w_ready; in that same cycle drive mac_weight_in=w_data, mac_preload_weight=1.
REQ-011 SHALL assert w_ready in FETCH, and in STREAM while a further weight remains and none is already preloaded; otherwise w_ready=0.
REQ-012 SHALL assert mac_load_weight for one cycle, never in the same cycle as the preload of that weight (preload then load, ≥1 cycle apart).
REQ-013 SHALL go FETCH->LOAD on weight transfer, LOAD->STREAM after the single load cycle.
REQ-014 SHALL assert a_ready only in STREAM; each a_valid&&a_ready cycle drives mac_enable=1, mac_input_val=a_data, else mac_enable=0, mac_input_val held.
REQ-015 SHALL, on the last activation of a tile with the next weight already preloaded, assert mac_load_weight in that same cycle and remain in STREAM (zero-bubble tile switch).
REQ-016 SHALL, on the last activation of a tile with next weight not yet preloaded, go to FETCH; with no tiles remaining, go to DRAIN.
REQ-017 SHALL keep an outstanding-result counter: +1 per mac_enable, -1 per mac_out_valid, both in one cycle = no change; width covers MAX_LEN*MAX_TILES.
REQ-018 SHALL leave DRAIN when outstanding==0 and no increment that cycle, enter DONE, pulse done=1 for exactly one cycle, then IDLE.
REQ-019 SHALL ignore mac_out_valid in IDLE (counter not decremented below 0).
REQ-020 SHALL present no combinational path from a_valid or w_valid to a_ready or w_ready.

Reset
REQ-021 SHALL on reset force state IDLE, counters 0, preload flag 0, and all outputs to 0 (busy, done, w_ready, a_ready, mac_* strobes, mac_weight_in, mac_input_val).
REQ-022 SHALL on reset mid-job abandon the job with no done pulse; the MAC shares this reset.

Structure
REQ-023 SHALL take DATA_W default and the state enum type from the shared package mac_pkg.
REQ-024 SHALL be a single module with no sub-modules; the counters and FSM are inline.

Verification
REQ-025 cfg_len=3, cfg_tiles=1, w=5, a=1,2,3 back-to-back -> one preload, one load, 3 enables, MAC results 5,10,15, done 1 cycle after the 3rd mac_out_valid.
REQ-026 cfg_len=2, cfg_tiles=3, weights 2,-3,4 available early -> loads of -3 and 4 coincide with the last enable of the prior tile, 6 enables in 6 consecutive cycles, results 2a0,2a1,-3a2,...
REQ-027 cfg_len=2, cfg_tiles=2, second weight delayed 5 cycles -> FETCH entered, a_ready=0 until load completes, no enable in that gap.
REQ-028 a_valid toggled 1,0,1,0 -> mac_enable follows the transfers only; outstanding never negative; done after the final result.
REQ-029 start with cfg_len=0 -> done pulse next cycle, no preload/load/enable; start asserted while busy -> ignored.
REQ-030 reset asserted mid-STREAM -> all outputs 0 next edge, busy=0, no done; a fresh job then completes normally.
